// File: rtl/arith_pkg.sv
// Shared constants for the arithmetic unit set.
package arith_pkg;
  localparam int DEFAULT_WIDTH = 4;
endpackage

// File: rtl/rca_full_adder.sv
// Single full-adder cell used in every ripple-carry row of the array multiplier.
module rca_full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

// File: rtl/rca_array_multiplier.sv
// Unsigned WIDTH x WIDTH array multiplier: AND partial products reduced by rows of
// ripple-carry adders, with the 2*WIDTH-bit product registered (1-cycle latency).
module rca_array_multiplier
  import arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic               in_valid,
  output logic [2*WIDTH-1:0] S,
  output logic               out_valid
);
  logic [WIDTH-1:0][WIDTH-1:0] pp;
  logic [WIDTH-1:0][WIDTH-1:0] rsum;
  logic [WIDTH-1:0]            rowc;
  logic [WIDTH-1:1][WIDTH-1:0] xop;
  logic [WIDTH-1:1][WIDTH:0]   carry;
  logic [2*WIDTH-1:0]          prod;

  // pp[i] is the multiplicand gated by multiplier bit i
  for (genvar i = 0; i < WIDTH; i++) begin : g_pp
    for (genvar j = 0; j < WIDTH; j++) begin : g_ppb
      assign pp[i][j] = A[j] & B[i];
    end
  end

  assign rsum[0] = pp[0];
  assign rowc[0] = 1'b0;

  // Each row adds pp[i] to the previous running sum shifted down one bit;
  // the bit shifted out is a finished product bit.
  for (genvar i = 1; i < WIDTH; i++) begin : g_row
    assign xop[i]      = {rowc[i-1], rsum[i-1][WIDTH-1:1]};
    assign carry[i][0] = 1'b0;
    for (genvar j = 0; j < WIDTH; j++) begin : g_fa
      rca_full_adder u_fa (
        .a   (xop[i][j]),
        .b   (pp[i][j]),
        .cin (carry[i][j]),
        .sum (rsum[i][j]),
        .cout(carry[i][j+1])
      );
    end
    assign rowc[i] = carry[i][WIDTH];
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_lo
    assign prod[i] = rsum[i][0];
  end
  assign prod[2*WIDTH-1:WIDTH] = {rowc[WIDTH-1], rsum[WIDTH-1][WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      S         <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) S <= prod;
    end
  end
endmodule

// File: tb/tb_rca_array_multiplier.sv
// Directed and exhaustive/random checks of the RCA array multiplier at WIDTH 4, 8, 16.
module tb_rca_array_multiplier;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  a4, b4;
  logic [7:0]  a8, b8;
  logic [15:0] a16, b16;
  logic        v4, v8, v16;
  logic [7:0]  s4;
  logic [15:0] s8;
  logic [31:0] s16;
  logic        ov4, ov8, ov16;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  rca_array_multiplier #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .A(a4), .B(b4), .in_valid(v4), .S(s4), .out_valid(ov4));
  rca_array_multiplier #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .A(a8), .B(b8), .in_valid(v8), .S(s8), .out_valid(ov8));
  rca_array_multiplier #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .A(a16), .B(b16), .in_valid(v16), .S(s16), .out_valid(ov16));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mul4(input logic [3:0] a, input logic [3:0] b, input logic [7:0] exp,
                      input string tag);
    a4 = a; b4 = b; v4 = 1'b1;
    cyc();
    chk({tag, ".S"}, 64'(s4), 64'(exp));
    chk({tag, ".ov"}, 64'(ov4), 64'd1);
  endtask

  initial begin
    rst = 1'b1; v4 = 1'b1; a4 = 4'd13; b4 = 4'd14;
    v8 = 1'b0; a8 = '0; b8 = '0; v16 = 1'b0; a16 = '0; b16 = '0;
    for (int k = 0; k < 2; k++) begin
      cyc();
      chk("rst.S", 64'(s4), 64'd0);
      chk("rst.ov", 64'(ov4), 64'd0);
    end
    chk("rst.S8", 64'(s8), 64'd0);
    chk("rst.S16", 64'(s16), 64'd0);
    rst = 1'b0;

    mul4(4'd13, 4'd14, 8'd182, "nom");
    mul4(4'd15, 4'd15, 8'd225, "max");
    mul4(4'd0,  4'd15, 8'd0,   "zero");
    mul4(4'd1,  4'd9,  8'd9,   "one");
    mul4(4'd8,  4'd8,  8'd64,  "msb");

    mul4(4'd3,  4'd5,  8'd15,  "strm0");
    mul4(4'd7,  4'd6,  8'd42,  "strm1");
    v4 = 1'b0; a4 = 4'd15; b4 = 4'd15;
    cyc();
    chk("idle.S", 64'(s4), 64'd42);
    chk("idle.ov", 64'(ov4), 64'd0);
    mul4(4'd12, 4'd11, 8'd132, "strm2");

    rst = 1'b1; v4 = 1'b1; a4 = 4'd9; b4 = 4'd9;
    cyc();
    chk("midrst.S", 64'(s4), 64'd0);
    chk("midrst.ov", 64'(ov4), 64'd0);
    rst = 1'b0; v4 = 1'b0;
    cyc();
    chk("postrst.S", 64'(s4), 64'd0);
    chk("postrst.ov", 64'(ov4), 64'd0);

    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        a4 = 4'(i); b4 = 4'(j); v4 = 1'b1;
        cyc();
        chk("exh4", 64'(s4), 64'(i * j));
      end
    end
    v4 = 1'b0;

    for (int k = 0; k < 10000; k++) begin
      logic [15:0] e8;
      logic [31:0] e16;
      a8  = 8'($urandom);  b8  = 8'($urandom);
      a16 = 16'($urandom); b16 = 16'($urandom);
      if (k == 0) begin a8 = 8'hFF; b8 = 8'hFF; a16 = 16'hFFFF; b16 = 16'hFFFF; end
      v8 = 1'b1; v16 = 1'b1;
      e8  = 16'(a8) * 16'(b8);
      e16 = 32'(a16) * 32'(b16);
      cyc();
      chk("rnd8", 64'(s8), 64'(e8));
      chk("rnd16", 64'(s16), 64'(e16));
    end
    chk("rnd8.ov", 64'(ov8), 64'd1);
    chk("rnd16.ov", 64'(ov16), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
